pwm_breath_multi: RTL and testbench
===================================

Name: pwm_breath_multi

Overview:
Multi-channel PWM LED driver; successor to the single-channel 1 kHz breathing LED block. One shared period counter drives NUM_CH channels. Each channel selects a mode per channel: off, static duty, breathing (triangular duty ramp) or blink. Sits between board-level LED pins and control logic/registers; outputs drive LEDs directly.

Parameters:
NUM_CH, 4, number of PWM channels
CNT_W, 16, width of period counter and duty values
PERIOD, 12000, clocks per PWM period (1 kHz at 12 MHz); legal range 2..2^CNT_W-1
STEP, 1, breathing duty increment/decrement per PWM period
BLINK_DIV, 500, PWM periods per blink half-cycle
STAGGER, 0, 1 = breathing channel i starts at duty (i*PERIOD)/NUM_CH, 0 = all start at 0
ACTIVE_LOW, 0, 1 = invert pwm_out (LED lit when pin low)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable
mode  input  2*NUM_CH  per-channel mode, ch i at [2i+1:2i]: 00 off, 01 static, 10 breath, 11 blink
duty_in  input  CNT_W*NUM_CH  per-channel static duty, ch i at [CNT_W*i +: CNT_W]
pwm_out  output  NUM_CH  registered PWM outputs
period_tick  output  1  one-cycle pulse on last clock of each PWM period
dir_up  output  NUM_CH  current breathing direction per channel (1 = rising)

Behaviour:
- Reset (rst_n low, async): cnt=0, period_tick=0, blink counter=0, blink phase=0, shadow modes=00, breath duty=stagger init (or 0), dir_up=all 1, pwm_out = all ACTIVE_LOW (i.e. LED dark).
- Period counter: cnt increments 0..PERIOD-1 when en=1, wraps to 0. period_tick=1 (registered) during the cycle cnt==PERIOD-1 is presented, else 0.
- en=0: cnt held at 0, period_tick=0, all breath/blink state frozen, pwm_out driven dark on next edge. en rising resumes from cnt=0.
- Shadow mode/duty: mode and duty_in sampled into shadow registers only at the period wrap (cnt==PERIOD-1 -> 0) and once at first enabled cycle after reset; changes mid-period never alter the current period (glitch-free).
- Effective duty d_i: off -> 0; static -> min(duty_in_shadow, PERIOD); breath -> breath duty register; blink -> PERIOD if blink phase=1 else 0.
- Output: pwm_out[i] = (cnt < d_i) XOR ACTIVE_LOW, registered; latency 1 clock from cnt. d=0 -> never lit; d>=PERIOD -> lit for whole period.
- Breathing update, per channel, at period wrap only when shadow mode=10: rising: if duty+STEP >= PERIOD then duty=PERIOD, dir_up=0 else duty+=STEP. Falling: if duty <= STEP then duty=0, dir_up=1 else duty-=STEP. Arithmetic CNT_W+1 bits, no wrap-around.
- Entering breath mode (shadow changes to 10 from other mode): duty restarts at stagger init value, dir_up=1, effective from that period.
- Blink: shared period counter counts wraps 0..BLINK_DIV-1; blink phase toggles when it wraps. Counter runs regardless of mode.
- Non-breath channels hold breath duty and dir_up unchanged.
- Reset asserted mid-period: all state returns to reset values immediately; no partial pulse completion.

Test Plan:
- Reset/idle: PERIOD=10, rst_n low then high, en=0 -> pwm_out=0, period_tick=0, cnt stays 0 for 50 clocks.
- Static: PERIOD=10, ch0 static duty_in=3, ch1 duty_in=15, en=1 -> ch0 high 3 of every 10 clocks (1 clock after cnt 0..2); ch1 always high; period_tick every 10th clock.
- Breath clamp: PERIOD=10, STEP=3, ch0 breath -> duty per period 0,3,6,9,10,7,4,1,0,3; dir_up drops when 10 reached, rises at 0.
- Mid-period change: switch ch0 static 2->8 at cnt=5 -> current period stays 2-high, next period 8-high; no extra edges.
- Stagger/blink: NUM_CH=4, STAGGER=1, PERIOD=12 -> breath start duties 0,3,6,9; blink ch with BLINK_DIV=2 -> 2 periods fully on, 2 off.
- Async reset mid-operation and ACTIVE_LOW=1: rst_n low at cnt=4 with outputs lit -> pwm_out=all 1 same cycle, no clock edge required.

Source files
------------

// File: rtl/pwm_breath_multi.sv
// Multi-channel PWM LED driver. One shared period counter feeds NUM_CH
// channels, each running off, static-duty, triangular breathing or blink.
module pwm_breath_multi #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERIOD     = 12000,
  parameter int unsigned STEP       = 1,
  parameter int unsigned BLINK_DIV  = 500,
  parameter int unsigned STAGGER    = 0,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [CNT_W*NUM_CH-1:0] duty_in,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic [NUM_CH-1:0]       dir_up
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STATIC = 2'b01,
    MODE_BREATH = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  localparam int unsigned     BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   STEP_C    = (CNT_W+1)'(STEP);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic             AL        = (ACTIVE_LOW != 0);

  function automatic logic [CNT_W-1:0] init_duty(input int unsigned ch);
    longint unsigned prod;
    prod = longint'(ch) * longint'(PERIOD);
    if (STAGGER != 0) return CNT_W'(prod / longint'(NUM_CH));
    else              return '0;
  endfunction

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          tick_q, tick_d;
  logic [BW-1:0]                 bcnt_q, bcnt_d;
  logic                          bph_q, bph_d;
  logic                          loaded_q, loaded_d;
  logic [NUM_CH-1:0][1:0]        mode_sh_q, mode_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  duty_sh_q, duty_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  breath_q, breath_d;
  logic [NUM_CH-1:0]             dir_q, dir_d;
  logic [NUM_CH-1:0]             pwm_q, pwm_d;

  logic                          wrap, first, load;
  logic [NUM_CH-1:0][1:0]        mode_cur;
  logic [NUM_CH-1:0][CNT_W-1:0]  duty_cur;
  logic [NUM_CH-1:0][CNT_W-1:0]  eff_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      bcnt_q    <= '0;
      bph_q     <= 1'b0;
      loaded_q  <= 1'b0;
      mode_sh_q <= '0;
      duty_sh_q <= '0;
      dir_q     <= '1;
      pwm_q     <= {NUM_CH{AL}};
      for (int unsigned i = 0; i < NUM_CH; i++) breath_q[i] <= init_duty(i);
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      bcnt_q    <= bcnt_d;
      bph_q     <= bph_d;
      loaded_q  <= loaded_d;
      mode_sh_q <= mode_sh_d;
      duty_sh_q <= duty_sh_d;
      breath_q  <= breath_d;
      dir_q     <= dir_d;
      pwm_q     <= pwm_d;
    end
  end

  always_comb begin
    wrap      = en && (cnt_q == LAST_C);
    first     = en && !loaded_q;
    load      = wrap || first;
    cnt_d     = en ? (wrap ? '0 : cnt_q + CNT_W'(1)) : '0;
    // Tick is registered but aligned with the cycle presenting the last count.
    tick_d    = en && (cnt_d == LAST_C);
    loaded_d  = loaded_q | en;
    mode_sh_d = load ? mode    : mode_sh_q;
    duty_sh_d = load ? duty_in : duty_sh_q;

    bcnt_d = bcnt_q;
    bph_d  = bph_q;
    if (wrap) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    // The very first enabled cycle must already use the freshly sampled settings.
    mode_cur = first ? mode    : mode_sh_q;
    duty_cur = first ? duty_in : duty_sh_q;

    breath_d = breath_q;
    dir_d    = dir_q;
    eff_duty = '0;
    pwm_d    = {NUM_CH{AL}};
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (load && (mode_e'(mode_sh_d[i]) == MODE_BREATH)) begin
        if (mode_e'(mode_sh_q[i]) != MODE_BREATH) begin
          breath_d[i] = init_duty(i);
          dir_d[i]    = 1'b1;
        end else if (dir_q[i]) begin
          if (({1'b0, breath_q[i]} + STEP_C) >= {1'b0, PERIOD_C}) begin
            breath_d[i] = PERIOD_C;
            dir_d[i]    = 1'b0;
          end else begin
            breath_d[i] = breath_q[i] + STEP_C[CNT_W-1:0];
          end
        end else begin
          if ({1'b0, breath_q[i]} <= STEP_C) begin
            breath_d[i] = '0;
            dir_d[i]    = 1'b1;
          end else begin
            breath_d[i] = breath_q[i] - STEP_C[CNT_W-1:0];
          end
        end
      end

      case (mode_e'(mode_cur[i]))
        MODE_OFF:    eff_duty[i] = '0;
        MODE_STATIC: eff_duty[i] = (duty_cur[i] > PERIOD_C) ? PERIOD_C : duty_cur[i];
        MODE_BREATH: eff_duty[i] = breath_q[i];
        MODE_BLINK:  eff_duty[i] = bph_q ? PERIOD_C : '0;
        default:     eff_duty[i] = '0;
      endcase

      pwm_d[i] = en ? ((cnt_q < eff_duty[i]) ^ AL) : AL;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign dir_up      = dir_q;

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Directed bench: instance A (2 ch, PERIOD=10, STEP=3, BLINK_DIV=2) and
// instance B (4 ch, PERIOD=12, STAGGER=1, ACTIVE_LOW=1).
module tb_pwm_breath_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, en_a = 1'b0, tick_a;
  logic [3:0]  mode_a = '0;
  logic [31:0] duty_a = '0;
  logic [1:0]  pwm_a, dir_a;

  logic        rst_b = 1'b0, en_b = 1'b0, tick_b;
  logic [7:0]  mode_b = '0;
  logic [63:0] duty_b = '0;
  logic [3:0]  pwm_b, dir_b;

  int vectors = 0;
  int miscompares = 0;

  pwm_breath_multi #(
    .NUM_CH(2), .CNT_W(16), .PERIOD(10), .STEP(3),
    .BLINK_DIV(2), .STAGGER(0), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .mode(mode_a), .duty_in(duty_a),
    .pwm_out(pwm_a), .period_tick(tick_a), .dir_up(dir_a)
  );

  pwm_breath_multi #(
    .NUM_CH(4), .CNT_W(16), .PERIOD(12), .STEP(1),
    .BLINK_DIV(2), .STAGGER(1), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b), .mode(mode_b), .duty_in(duty_b),
    .pwm_out(pwm_b), .period_tick(tick_b), .dir_up(dir_b)
  );

  task automatic reset_a();
    en_a  = 1'b0;
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic reset_b();
    en_b  = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_a();
    vectors++;
    if (dir_a !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_dir_a: got %b expected 11", dir_a);
    end
    for (int k = 0; k < 50; k++) begin
      vectors++;
      if (pwm_a !== 2'b00 || tick_a !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_a k=%0d: pwm=%b tick=%b expected pwm=00 tick=0", k, pwm_a, tick_a);
      end
      @(negedge clk);
    end
    en_b  = 1'b0;
    rst_b = 1'b0;
    #1;
    vectors++;
    if (pwm_b !== 4'hF || dir_b !== 4'hF || tick_b !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b: pwm=%b dir=%b tick=%b expected 1111/1111/0", pwm_b, dir_b, tick_b);
    end
  endtask

  task automatic test_static();
    logic [1:0] exp_pwm;
    reset_a();
    mode_a = {2'b01, 2'b01};
    duty_a = {16'd15, 16'd3};
    en_a   = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_pwm[0] = ((k - 1) % 10) < 3;
      exp_pwm[1] = 1'b1;
      vectors++;
      if (pwm_a !== exp_pwm || tick_a !== ((k % 10) == 9)) begin
        miscompares++;
        $display("FAIL static k=%0d: pwm=%b tick=%b expected pwm=%b tick=%b",
                 k, pwm_a, tick_a, exp_pwm, ((k % 10) == 9));
      end
    end
  endtask

  task automatic test_mid_period_change();
    logic [1:0] exp_pwm;
    int lim;
    reset_a();
    mode_a = {2'b00, 2'b01};
    duty_a = {16'd0, 16'd2};
    en_a   = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      lim = (k <= 10) ? 2 : 8;
      exp_pwm[0] = ((k - 1) % 10) < lim;
      exp_pwm[1] = 1'b0;
      vectors++;
      if (pwm_a !== exp_pwm) begin
        miscompares++;
        $display("FAIL mid_change k=%0d: pwm=%b expected %b", k, pwm_a, exp_pwm);
      end
      if (k == 5) duty_a[15:0] = 16'd8;
    end
  endtask

  task automatic test_breath_blink();
    int d_tab [11]   = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3, 6};
    bit dir_tab [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    logic [1:0] exp_pwm, exp_dir;
    int p, c;
    reset_a();
    mode_a = {2'b11, 2'b10};
    duty_a = '0;
    en_a   = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      p = (k - 1) / 10;
      c = (k - 1) % 10;
      exp_pwm[0] = c < d_tab[p];
      exp_pwm[1] = ((p / 2) % 2) == 1;
      exp_dir    = {1'b1, dir_tab[k / 10]};
      vectors++;
      if (pwm_a !== exp_pwm || dir_a !== exp_dir) begin
        miscompares++;
        $display("FAIL breath_blink k=%0d: pwm=%b dir=%b expected pwm=%b dir=%b",
                 k, pwm_a, dir_a, exp_pwm, exp_dir);
      end
    end
  endtask

  task automatic test_enable_gate();
    logic [1:0] exp_pwm;
    reset_a();
    mode_a = {2'b10, 2'b01};
    duty_a = {16'd0, 16'd3};
    en_a   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_pwm = {1'b0, ((k - 1) < 3) ? 1'b1 : 1'b0};
      vectors++;
      if (pwm_a !== exp_pwm) begin
        miscompares++;
        $display("FAIL gate_pre k=%0d: pwm=%b expected %b", k, pwm_a, exp_pwm);
      end
    end
    en_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if (pwm_a !== 2'b00 || tick_a !== 1'b0) begin
        miscompares++;
        $display("FAIL gate_off k=%0d: pwm=%b tick=%b expected 00/0", k, pwm_a, tick_a);
      end
    end
    en_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_pwm[0] = ((k - 1) % 10) < 3;
      exp_pwm[1] = (k > 10) && (((k - 1) % 10) < 3);
      vectors++;
      if (pwm_a !== exp_pwm || tick_a !== ((k % 10) == 9)) begin
        miscompares++;
        $display("FAIL gate_resume k=%0d: pwm=%b tick=%b expected pwm=%b tick=%b",
                 k, pwm_a, tick_a, exp_pwm, ((k % 10) == 9));
      end
    end
  endtask

  task automatic check_stagger(input int k, input string tag);
    logic [3:0] exp_pwm;
    int p, c;
    p = (k - 1) / 12;
    c = (k - 1) % 12;
    for (int i = 0; i < 4; i++) exp_pwm[i] = !(c < (3 * i + p));
    vectors++;
    if (pwm_b !== exp_pwm || dir_b !== 4'hF || tick_b !== ((k % 12) == 11)) begin
      miscompares++;
      $display("FAIL %s k=%0d: pwm=%b dir=%b tick=%b expected pwm=%b dir=1111 tick=%b",
               tag, k, pwm_b, dir_b, tick_b, exp_pwm, ((k % 12) == 11));
    end
  endtask

  task automatic test_stagger_async_reset();
    reset_b();
    mode_b = 8'b10_10_10_10;
    duty_b = '0;
    en_b   = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check_stagger(k, "stagger");
    end
    rst_b = 1'b0;
    #1;
    vectors++;
    if (pwm_b !== 4'hF || tick_b !== 1'b0 || dir_b !== 4'hF) begin
      miscompares++;
      $display("FAIL async_reset: pwm=%b tick=%b dir=%b expected 1111/0/1111", pwm_b, tick_b, dir_b);
    end
    @(negedge clk);
    vectors++;
    if (pwm_b !== 4'hF || tick_b !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: pwm=%b tick=%b expected 1111/0", pwm_b, tick_b);
    end
    rst_b = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_stagger(k, "post_reset");
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_mid_period_change();
    test_breath_blink();
    test_enable_gate();
    test_stagger_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
